// File: rtl/fpu_q_pkg.sv
// Shared types and constants for the FPU result queue.
//   fpu_unit_e    : binary index of the FPU unit that produced a result
//   FLG_*         : bit positions inside the 5-bit {NV,DZ,OF,UF,NX} flag field
//   fpu_q_entry_t : one queued result {data, flags, unit}
package fpu_q_pkg;

  localparam int unsigned Q_DATA_W = 32;
  localparam int unsigned Q_NUM_U  = 11;
  localparam int unsigned FLAG_W   = 5;
  localparam int unsigned UNIT_W   = 4;

  localparam int unsigned FLG_NV = 4;
  localparam int unsigned FLG_DZ = 3;
  localparam int unsigned FLG_OF = 2;
  localparam int unsigned FLG_UF = 1;
  localparam int unsigned FLG_NX = 0;

  typedef enum logic [UNIT_W-1:0] {
    FCLASS  = 4'd0,
    CMP     = 4'd1,
    MINMAX  = 4'd2,
    SGNJ    = 4'd3,
    CVT_F2I = 4'd4,
    CVT_I2F = 4'd5,
    ADD     = 4'd6,
    MUL     = 4'd7,
    FMA     = 4'd8,
    DIV     = 4'd9,
    SQRT    = 4'd10
  } fpu_unit_e;

  typedef struct packed {
    logic [Q_DATA_W-1:0] data;
    logic [FLAG_W-1:0]   flags;
    fpu_unit_e           unit;
  } fpu_q_entry_t;

endpackage

// File: rtl/fpu_q_onehot_enc.sv
// Lowest-set-bit encoder for the unit-valid vector.
//   onehot : unit-valid vector (normally one-hot; extra bits are ignored)
//   idx    : index of the lowest set bit, 0 when none set
//   hit    : any bit set
module fpu_onehot_enc
  import fpu_q_pkg::*;
#(
  parameter int unsigned NUM_U = Q_NUM_U
) (
  input  logic [NUM_U-1:0]  onehot,
  input  logic              unused_tie,
  output logic [UNIT_W-1:0] idx,
  output logic              hit
);

  // Scan high to low so the lowest set bit is the last (winning) assignment.
  always_comb begin
    idx = '0;
    hit = |onehot;
    for (int i = int'(NUM_U) - 1; i >= 0; i--) begin
      if (onehot[i]) idx = UNIT_W'(i);
    end
  end

endmodule

// File: rtl/fpu_result_queue.sv
// Result queue behind the FPU: buffers completed results in a FWFT FIFO,
// keeps sticky fflags / overflow state and drives a level interrupt.
//   clk, rst                       : clock, async active-high reset
//   res_valid/res_data/res_flags   : incoming result (push when any valid bit set)
//   pop                            : dequeue head
//   clr_flags                      : clear sticky fflags and ovf
//   irq_en                         : interrupt enable
//   rd_data/rd_unit/rd_flags       : head entry, zero while empty
//   empty/full/count               : occupancy status
//   fflags/ovf/irq                 : sticky flags, drop indicator, interrupt
module fpu_result_queue
  import fpu_q_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = Q_DATA_W,
  parameter int unsigned NUM_U  = Q_NUM_U
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_U-1:0]       res_valid,
  input  logic [DATA_W-1:0]      res_data,
  input  logic [FLAG_W-1:0]      res_flags,
  input  logic                   pop,
  input  logic                   clr_flags,
  input  logic                   irq_en,
  output logic [DATA_W-1:0]      rd_data,
  output logic [UNIT_W-1:0]      rd_unit,
  output logic [FLAG_W-1:0]      rd_flags,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic [FLAG_W-1:0]      fflags,
  output logic                   ovf,
  output logic                   irq
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned PTR_W = AW + 1;

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FLAG_W-1:0] fflags_q, fflags_d;
  logic              ovf_q, ovf_d;
  logic              irq_q, irq_d;
  fpu_q_entry_t      mem_q [DEPTH];
  fpu_q_entry_t      mem_d [DEPTH];

  logic [UNIT_W-1:0] enc_idx;
  logic              push_req;
  logic              q_empty, q_full;
  logic              do_pop, do_push, drop;
  fpu_q_entry_t      new_entry, head;

  fpu_onehot_enc #(.NUM_U(NUM_U)) u_enc (
    .onehot     (res_valid),
    .unused_tie (1'b0),
    .idx        (enc_idx),
    .hit        (push_req)
  );

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign q_empty = (wr_ptr_q == rd_ptr_q);
  assign q_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A pop frees a slot in the same cycle, so a full queue still accepts push+pop.
  assign do_pop  = pop & ~q_empty;
  assign do_push = push_req & (~q_full | do_pop);
  assign drop    = push_req & q_full & ~do_pop;

  assign new_entry = '{data:  Q_DATA_W'(res_data),
                       flags: res_flags,
                       unit:  fpu_unit_e'(enc_idx)};
  assign head      = mem_q[rd_ptr_q[AW-1:0]];

  // Next-state for pointers, storage and sticky status.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = new_entry;
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    // Flags accumulate on every attempt, including dropped results; a set wins over a clear.
    fflags_d = (clr_flags ? '0 : fflags_q) | (push_req ? res_flags : '0);
    ovf_d    = (clr_flags ? 1'b0 : ovf_q) | drop;
    // Built from next-state so irq rises together with the first entry.
    irq_d    = irq_en & ((wr_ptr_d != rd_ptr_d) | ovf_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fflags_q <= '0;
      ovf_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fflags_q <= fflags_d;
      ovf_q    <= ovf_d;
      irq_q    <= irq_d;
    end
  end

  // Storage carries no reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_data  = q_empty ? '0 : DATA_W'(head.data);
  assign rd_unit  = q_empty ? '0 : UNIT_W'(head.unit);
  assign rd_flags = q_empty ? '0 : head.flags;
  assign empty    = q_empty;
  assign full     = q_full;
  assign count    = wr_ptr_q - rd_ptr_q;
  assign fflags   = fflags_q;
  assign ovf      = ovf_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_fpu_result_queue.sv
// Randomized self-checking bench for fpu_result_queue against a queue-based model.
module tb_fpu_result_queue;
  import fpu_q_pkg::*;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned NUM_U  = 11;
  localparam int unsigned CW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [NUM_U-1:0]  res_valid;
  logic [DATA_W-1:0] res_data;
  logic [4:0]        res_flags;
  logic              pop, clr_flags, irq_en;
  logic [DATA_W-1:0] rd_data;
  logic [3:0]        rd_unit;
  logic [4:0]        rd_flags;
  logic              empty, full, ovf, irq;
  logic [CW-1:0]     count;
  logic [4:0]        fflags;

  fpu_result_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .NUM_U(NUM_U)) dut (
    .clk(clk), .rst(rst), .res_valid(res_valid), .res_data(res_data),
    .res_flags(res_flags), .pop(pop), .clr_flags(clr_flags), .irq_en(irq_en),
    .rd_data(rd_data), .rd_unit(rd_unit), .rd_flags(rd_flags), .empty(empty),
    .full(full), .count(count), .fflags(fflags), .ovf(ovf), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic [4:0]  f;
    logic [3:0]  u;
  } ment_t;

  ment_t      mq[$];
  logic [4:0] m_ff;
  logic       m_ovf;
  logic       m_irq;
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] low_idx(input logic [NUM_U-1:0] v);
    for (int i = 0; i < int'(NUM_U); i++) if (v[i]) return 4'(i);
    return 4'd0;
  endfunction

  task automatic check_all(input string tag);
    logic [31:0] ed;
    logic [4:0]  ef;
    logic [3:0]  eu;
    ed = '0; ef = '0; eu = '0;
    if (mq.size() > 0) begin
      ed = mq[0].d; ef = mq[0].f; eu = mq[0].u;
    end
    check({tag, ".count"},  64'(count),    64'(mq.size()));
    check({tag, ".empty"},  64'(empty),    64'(mq.size() == 0));
    check({tag, ".full"},   64'(full),     64'(mq.size() == int'(DEPTH)));
    check({tag, ".rd_data"}, 64'(rd_data), 64'(ed));
    check({tag, ".rd_unit"}, 64'(rd_unit), 64'(eu));
    check({tag, ".rd_flags"}, 64'(rd_flags), 64'(ef));
    check({tag, ".fflags"}, 64'(fflags),   64'(m_ff));
    check({tag, ".ovf"},    64'(ovf),      64'(m_ovf));
    check({tag, ".irq"},    64'(irq),      64'(m_irq));
  endtask

  // One clock: apply inputs, update the model at the edge, check #1 later.
  task automatic step(input string tag, input logic [NUM_U-1:0] v, input logic [31:0] d,
                      input logic [4:0] f, input logic p, input logic c);
    ment_t e;
    bit    popok;
    res_valid = v; res_data = d; res_flags = f; pop = p; clr_flags = c;
    @(posedge clk);
    if (rst) begin
      mq.delete(); m_ff = '0; m_ovf = 1'b0; m_irq = 1'b0;
    end else begin
      popok = p && (mq.size() > 0);
      if (c) begin m_ff = '0; m_ovf = 1'b0; end
      if (v != '0) m_ff = m_ff | f;
      if (popok) void'(mq.pop_front());
      if (v != '0) begin
        if (mq.size() < int'(DEPTH)) begin
          e.d = d; e.f = f; e.u = low_idx(v);
          mq.push_back(e);
        end else begin
          m_ovf = 1'b1;
        end
      end
      m_irq = irq_en && (mq.size() > 0 || m_ovf);
    end
    #1;
    res_valid = '0; pop = 1'b0; clr_flags = 1'b0;
    check_all(tag);
  endtask

  task automatic drain();
    int guard = 0;
    while (mq.size() > 0 && guard < 2 * int'(DEPTH)) begin
      step("drain", '0, '0, '0, 1'b1, 1'b0);
      guard++;
    end
    check("drain.done", 64'(mq.size()), 64'd0);
  endtask

  function automatic logic [NUM_U-1:0] rand_valid();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return NUM_U'(1) << $urandom_range(0, NUM_U - 1);
      2:       return NUM_U'($urandom);
      default: return NUM_U'(1) << $urandom_range(0, NUM_U - 1);
    endcase
  endfunction

  initial begin
    logic [31:0] tail_d;
    rst = 1'b1; res_valid = '0; res_data = '0; res_flags = '0;
    pop = 1'b0; clr_flags = 1'b0; irq_en = 1'b1;
    mq.delete(); m_ff = '0; m_ovf = 1'b0; m_irq = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;

    // Single add result
    step("add", 11'h040, 32'h3F80_0000, 5'b00001, 1'b0, 1'b0);
    check("add.unit6", 64'(rd_unit), 64'd6);

    // Fill, then overflow with a div carrying DZ
    for (int i = 0; i < int'(DEPTH) - 1; i++)
      step("fill", 11'h080, $urandom, 5'b00000, 1'b0, 1'b0);
    step("ovf_div", 11'h200, 32'hDEAD_BEEF, 5'b01000, 1'b0, 1'b0);
    check("ovf_div.dz", 64'(fflags[FLG_DZ]), 64'd1);
    check("ovf_div.head", 64'(rd_data), 64'h3F80_0000);

    // Clear, then push+pop while full
    step("clr", '0, '0, '0, 1'b0, 1'b1);
    tail_d = 32'hCAFE_0001;
    step("full_pp", 11'h001, tail_d, 5'b00010, 1'b1, 1'b0);
    for (int i = 0; i < int'(DEPTH) - 1; i++) step("full_pp.pop", '0, '0, '0, 1'b1, 1'b0);
    check("full_pp.tail", 64'(rd_data), 64'(tail_d));
    drain();

    // Pointer wrap with push/pop traffic
    for (int i = 0; i < 10; i++)
      step("wrap", NUM_U'(1) << $urandom_range(0, NUM_U - 1), $urandom, 5'($urandom),
           1'($urandom_range(0, 1)), 1'b0);
    drain();

    // Clear coincident with a push carrying NV
    step("clr_set", 11'h400, 32'h1234_5678, 5'b10000, 1'b0, 1'b1);
    check("clr_set.ff", 64'(fflags), 64'h10);

    // Multi-bit valid: lowest wins
    step("multi", 11'h610, 32'h0000_00AA, 5'b00100, 1'b0, 1'b0);

    // Disable interrupt
    irq_en = 1'b0;
    step("irq_off", '0, '0, '0, 1'b0, 1'b0);
    irq_en = 1'b1;
    step("irq_on", '0, '0, '0, 1'b0, 1'b0);
    drain();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      irq_en = ($urandom_range(0, 15) != 0);
      step("rand", rand_valid(), $urandom, 5'($urandom),
           1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 15) == 0));
    end
    drain();

    // Async reset mid-stream with three entries queued
    for (int i = 0; i < 3; i++) step("pre_rst", 11'h002, $urandom, 5'b00001, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    mq.delete(); m_ff = '0; m_ovf = 1'b0; m_irq = 1'b0;
    check("async_rst.empty", 64'(empty), 64'd1);
    check("async_rst.count", 64'(count), 64'd0);
    check("async_rst.irq",   64'(irq),   64'd0);
    check_all("async_rst");
    step("in_rst", 11'h004, 32'h5555_AAAA, 5'b11111, 1'b0, 1'b0);
    rst = 1'b0;
    step("post_rst", 11'h008, 32'hA5A5_5A5A, 5'b00010, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
